// File: rtl/sm_mul_seq.sv
// rtl/sm_mul_seq.sv - sequential sign-magnitude shift-add multiplier; optional remainder add under SM_MUL_REM_ADD_EN
module sm_mul_seq #(
    parameter int W = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   q_in,
    input  logic [W-1:0]   b_in,
    input  logic [W:0]     r_in,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);
    // Magnitude width of the operands, accumulator width, iteration counter width.
    localparam int MW = W - 1;
    localparam int AW = 2 * W - 1;
    localparam int CW = $clog2(W - 1);
    localparam logic [CW-1:0] LAST_IT = CW'(W - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
`ifdef SM_MUL_REM_ADD_EN
    localparam logic [1:0] S_ADD  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  mcand_q, mcand_d;
    logic [MW-1:0]  mplier_q, mplier_d;
    logic           sign_q, sign_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [2*W-1:0] p_q, p_d;
    logic [AW-1:0]  acc_step;

    // Pack a magnitude and sign into the output format; a zero magnitude never carries a sign.
    function automatic logic [2*W-1:0] pack_sm(input logic s, input logic [AW-1:0] m);
        return {s & (|m), m};
    endfunction

`ifdef SM_MUL_REM_ADD_EN
    logic           rsign_q, rsign_d;
    logic [W-1:0]   rmag_q, rmag_d;
    logic [AW-1:0]  rmag_ext;
    logic [AW-1:0]  sum_mag;
    logic           sum_sign;
    logic           prod_neg;

    // Sign-magnitude addition of the finished product and the latched remainder.
    always_comb begin
        rmag_ext = {{(AW-W){1'b0}}, rmag_q};
        prod_neg = sign_q & (|acc_q);
        sum_mag  = '0;
        sum_sign = 1'b0;
        if (prod_neg == rsign_q) begin
            sum_mag  = acc_q + rmag_ext;
            sum_sign = prod_neg;
        end else if (acc_q >= rmag_ext) begin
            sum_mag  = acc_q - rmag_ext;
            sum_sign = prod_neg;
        end else begin
            sum_mag  = rmag_ext - acc_q;
            sum_sign = rsign_q;
        end
    end
`else
    logic unused_r;
    assign unused_r = ^r_in;
`endif

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {AW{1'b0}});

    // Next-state and datapath control for IDLE/RUN/(ADD)/DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        acc_d    = acc_q;
        p_d      = p_q;
`ifdef SM_MUL_REM_ADD_EN
        rsign_d  = rsign_q;
        rmag_d   = rmag_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    mcand_d  = {{W{1'b0}}, q_in[MW-1:0]};
                    mplier_d = b_in[MW-1:0];
                    sign_d   = q_in[W-1] ^ b_in[W-1];
                    acc_d    = '0;
`ifdef SM_MUL_REM_ADD_EN
                    rsign_d  = r_in[W];
                    rmag_d   = r_in[W-1:0];
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_IT) begin
`ifdef SM_MUL_REM_ADD_EN
                    state_d = S_ADD;
`else
                    state_d = S_DONE;
                    p_d     = pack_sm(sign_q, acc_step);
`endif
                end
            end
`ifdef SM_MUL_REM_ADD_EN
            S_ADD: begin
                state_d = S_DONE;
                p_d     = pack_sm(sum_sign, sum_mag);
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including an operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
        end
    end

`ifdef SM_MUL_REM_ADD_EN
    // Latched remainder operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsign_q <= 1'b0;
            rmag_q  <= '0;
        end else begin
            rsign_q <= rsign_d;
            rmag_q  <= rmag_d;
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_ADD);
`else
    assign busy = (state_q == S_RUN);
`endif
    assign done = (state_q == S_DONE);
    assign p    = p_q;

endmodule

// File: tb/tb_sm_mul_seq.sv
// tb/tb_sm_mul_seq.sv - scoreboard bench for sm_mul_seq (directed vectors, abort, back-to-back, random)
module tb_sm_mul_seq;
    localparam int W = 5;
`ifdef SM_MUL_REM_ADD_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   q_in, b_in;
    logic [W:0]     r_in;
    logic           busy, done;
    logic [2*W-1:0] p;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [2*W-1:0] p;
        int             cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic [W-1:0]   q;
        logic [W-1:0]   b;
        logic [W:0]     r;
        logic [2*W-1:0] e_on;
        logic [2*W-1:0] e_off;
    } vec_t;
    vec_t vt[10];

    sm_mul_seq #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q_in  (q_in),
        .b_in  (b_in),
        .r_in  (r_in),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [2*W-1:0] exp_of(input vec_t v);
`ifdef SM_MUL_REM_ADD_EN
        return v.e_on;
`else
        return v.e_off;
`endif
    endfunction

    function automatic logic [2*W-1:0] model(input logic [W-1:0] q, input logic [W-1:0] b,
                                             input logic [W:0] r);
        int prod, val, mag;
        logic [31:0] mag_v;
        prod = int'(q[W-2:0]) * int'(b[W-2:0]);
        val  = (q[W-1] ^ b[W-1]) ? -prod : prod;
`ifdef SM_MUL_REM_ADD_EN
        val  = val + (r[W] ? -int'(r[W-1:0]) : int'(r[W-1:0]));
`else
        if (r === 'x) val = val;
`endif
        mag   = (val < 0) ? -val : val;
        mag_v = mag;
        return {(val < 0), mag_v[2*W-2:0]};
    endfunction

    // Monitor: every done pulse pops one expectation and checks value and cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got done=1 p=%0h required no done (cycle %0d)", p, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("p", {22'b0, p}, {22'b0, mon_e.p});
                    check("done_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] q, input logic [W-1:0] b, input logic [W:0] r,
                         input logic [2*W-1:0] e);
        exp_t x;
        @(posedge clk); #1;
        q_in = q; b_in = b; r_in = r; start = 1'b1;
        x.p = e; x.cyc = cyc + LAT;
        sb.push_back(x);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (LAT) @(posedge clk);
    endtask

    initial begin
        exp_t x;
        int t0;
        vt[0] = '{5'b00011, 5'b00010, 6'b000000, 10'b0000000110, 10'b0000000110};
        vt[1] = '{5'b11111, 5'b11111, 6'b000000, 10'b0011100001, 10'b0011100001};
        vt[2] = '{5'b10000, 5'b10101, 6'b000000, 10'b0000000000, 10'b0000000000};
        vt[3] = '{5'b00000, 5'b10011, 6'b000000, 10'b0000000000, 10'b0000000000};
        vt[4] = '{5'b10111, 5'b00010, 6'b100001, 10'b1000001111, 10'b1000001110};
        vt[5] = '{5'b01111, 5'b00010, 6'b100011, 10'b0000011011, 10'b0000011110};
        vt[6] = '{5'b01111, 5'b11111, 6'b011111, 10'b1011000010, 10'b1011100001};
        vt[7] = '{5'b00001, 5'b00011, 6'b100011, 10'b0000000000, 10'b0000000011};
        vt[8] = '{5'b00000, 5'b00101, 6'b100101, 10'b1000000101, 10'b0000000000};
        vt[9] = '{5'b10000, 5'b10000, 6'b100000, 10'b0000000000, 10'b0000000000};

        rst = 1'b1; start = 1'b0; q_in = '0; b_in = '0; r_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_p", {22'b0, p}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First vector with per-cycle busy checking.
        @(posedge clk); #1;
        q_in = vt[0].q; b_in = vt[0].b; r_in = vt[0].r; start = 1'b1;
        t0 = cyc;
        x.p = exp_of(vt[0]); x.cyc = t0 + LAT;
        sb.push_back(x);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            @(negedge clk);
            check("busy_in_op", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        check("busy_at_done", {31'b0, busy}, 32'd0);
        check("done_at_latency", {31'b0, done}, 32'd1);
        @(posedge clk);

        for (int i = 1; i < 10; i++) issue(vt[i].q, vt[i].b, vt[i].r, exp_of(vt[i]));

        // Start re-pulsed while busy must be ignored.
        @(posedge clk); #1;
        q_in = vt[1].q; b_in = vt[1].b; r_in = vt[1].r; start = 1'b1;
        x.p = exp_of(vt[1]); x.cyc = cyc + LAT;
        sb.push_back(x);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        q_in = vt[0].q; b_in = vt[0].b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (LAT + 2) @(posedge clk);

        // Reset mid-operation aborts without a done pulse.
        @(posedge clk); #1;
        q_in = vt[4].q; b_in = vt[4].b; r_in = vt[4].r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("busy_before_abort", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_p", {22'b0, p}, 32'd0);
        repeat (LAT + 3) @(posedge clk);

        // Start held high: back-to-back accepts from DONE.
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            q_in = vt[4+k].q; b_in = vt[4+k].b; r_in = vt[4+k].r;
            x.p = exp_of(vt[4+k]); x.cyc = t0 + (k + 1) * LAT;
            sb.push_back(x);
            repeat (LAT) @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (LAT + 1) @(posedge clk);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] rq, rb;
            logic [W:0]   rr;
            rq = W'($urandom);
            rb = W'($urandom);
            rr = (W+1)'($urandom);
            issue(rq, rb, rr, model(rq, rb, rr));
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
